// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants, the buffered write-beat struct and the byte-lane merge helper.
// Pure declarations: no latency, no flow control.
package axil_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXIL_DATA_W-1:0] data;
        logic [AXIL_STRB_W-1:0] strb;
    } wbeat_t;

    function automatic logic [AXIL_DATA_W-1:0] byte_merge(
        input logic [AXIL_DATA_W-1:0] old_val,
        input logic [AXIL_DATA_W-1:0] new_val,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < AXIL_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_wr_capture.sv
// One-entry AW and W buffers filled independently; commit_vld is high while both are full.
// Latency: commit one edge after the later handshake; AW/W ready drop while full or a response is pending.
module axil_wr_capture
    import axil_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [IDX_W-1:0] aw_idx,
    input  logic             aw_vld,
    output logic             aw_rdy,
    input  wbeat_t           w_dat,
    input  logic             w_vld,
    output logic             w_rdy,
    input  logic             resp_busy,
    output logic             commit_vld,
    output logic [IDX_W-1:0] commit_idx,
    output wbeat_t           commit_dat
);

    logic ready_en;
    logic aw_full;
    logic w_full;

    // ready_en keeps both READYs low while ARESETN is held low
    assign aw_rdy     = ready_en && !aw_full && !resp_busy;
    assign w_rdy      = ready_en && !w_full && !resp_busy;
    assign commit_vld = aw_full && w_full;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ready_en   <= 1'b0;
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            commit_idx <= '0;
            commit_dat <= '0;
        end else begin
            ready_en <= 1'b1;
            if (commit_vld) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (aw_vld && aw_rdy) begin
                    aw_full    <= 1'b1;
                    commit_idx <= aw_idx;
                end
                if (w_vld && w_rdy) begin
                    w_full     <= 1'b1;
                    commit_dat <= w_dat;
                end
            end
        end
    end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: NUM_REGS x 32b, WSTRB merge, read-only slots from ro_in; optional wr_pulse under AXIL_REGBANK_WPULSE_EN.
// Read data 2 edges after AR handshake, write response 1 edge after both AW/W are held; one read and one write outstanding.
module axil_regbank
    import axil_pkg::*;
#(
    parameter int                     NUM_REGS  = 8,
    parameter int                     ADDR_W    = 8,
    parameter logic [AXIL_DATA_W-1:0] RESET_VAL = 32'h0000_0000,
    parameter logic [NUM_REGS-1:0]    RO_MASK   = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [ADDR_W-1:0]               ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [AXIL_DATA_W-1:0]          RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    input  logic [ADDR_W-1:0]               AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [AXIL_DATA_W-1:0]          WDATA,
    input  logic [AXIL_STRB_W-1:0]          WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    output logic [NUM_REGS*AXIL_DATA_W-1:0] reg_out,
    input  logic [NUM_REGS*AXIL_DATA_W-1:0] ro_in
`ifdef AXIL_REGBANK_WPULSE_EN
    ,
    output logic [NUM_REGS-1:0]             wr_pulse
`endif
);

    localparam int IDX_W = ADDR_W - 2;

    logic [NUM_REGS*AXIL_DATA_W-1:0] reg_flat;

    logic                   ar_pending;
    logic [IDX_W-1:0]       ar_idx_q;
    logic                   rd_hit;
    logic [AXIL_DATA_W-1:0] rd_val;

    wbeat_t                 w_beat;
    logic                   commit_vld;
    logic [IDX_W-1:0]       commit_idx;
    wbeat_t                 commit_dat;
    logic [NUM_REGS-1:0]    wr_sel;
    logic                   wr_ok;
    logic                   wr_en;

    logic unused_ok;
    assign unused_ok = ^{ARPROT, AWPROT, ARADDR[1:0], AWADDR[1:0]};

    // Read side

    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx_q == IDX_W'(i)) begin
                rd_hit = 1'b1;
                rd_val = RO_MASK[i] ? ro_in[AXIL_DATA_W*i +: AXIL_DATA_W]
                                    : reg_flat[AXIL_DATA_W*i +: AXIL_DATA_W];
            end
        end
    end

    // ARREADY is registered, so it tracks !RVALID && !ar_pending one edge late
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ARREADY    <= 1'b0;
            ar_pending <= 1'b0;
            ar_idx_q   <= '0;
            RVALID     <= 1'b0;
            RDATA      <= '0;
            RRESP      <= RESP_OKAY;
        end else if (ARVALID && ARREADY) begin
            ARREADY    <= 1'b0;
            ar_pending <= 1'b1;
            ar_idx_q   <= ARADDR[ADDR_W-1:2];
        end else if (ar_pending) begin
            ar_pending <= 1'b0;
            RVALID     <= 1'b1;
            RDATA      <= rd_val;
            RRESP      <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (RVALID && RREADY) begin
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            ARREADY <= 1'b1;
        end else if (!RVALID) begin
            ARREADY <= 1'b1;
        end
    end

    // Write side

    assign w_beat = '{data: WDATA, strb: WSTRB};

    axil_wr_capture #(
        .IDX_W (IDX_W)
    ) u_wr_capture (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .aw_idx     (AWADDR[ADDR_W-1:2]),
        .aw_vld     (AWVALID),
        .aw_rdy     (AWREADY),
        .w_dat      (w_beat),
        .w_vld      (WVALID),
        .w_rdy      (WREADY),
        .resp_busy  (BVALID),
        .commit_vld (commit_vld),
        .commit_idx (commit_idx),
        .commit_dat (commit_dat)
    );

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = (commit_idx == IDX_W'(i));
        end
    end

    // An empty wr_sel means out-of-range; a hit on a read-only slot is refused as well
    assign wr_ok = |(wr_sel & ~RO_MASK);
    assign wr_en = commit_vld && wr_ok;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            BVALID <= 1'b0;
            BRESP  <= RESP_OKAY;
        end else if (commit_vld) begin
            BVALID <= 1'b1;
            BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (BVALID && BREADY) begin
            BVALID <= 1'b0;
            BRESP  <= RESP_OKAY;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign reg_flat[AXIL_DATA_W*g +: AXIL_DATA_W] = '0;
        end else begin : g_rw
            logic [AXIL_DATA_W-1:0] q;
            always_ff @(posedge ACLK) begin
                if (!ARESETN) begin
                    q <= RESET_VAL;
                end else if (wr_en && wr_sel[g]) begin
                    q <= byte_merge(q, commit_dat.data, commit_dat.strb);
                end
            end
            assign reg_flat[AXIL_DATA_W*g +: AXIL_DATA_W] = q;
        end
    end

    assign reg_out = reg_flat;

`ifdef AXIL_REGBANK_WPULSE_EN
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_pulse <= '0;
        end else if (wr_en && (|commit_dat.strb)) begin
            wr_pulse <= wr_sel;
        end else begin
            wr_pulse <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_axil_regbank.sv
// Directed plus randomized AXI4-Lite traffic against a behavioural register model.
module tb_axil_regbank;

    localparam int          NR  = 8;
    localparam int          AW  = 8;
    localparam logic [NR-1:0] ROM = 8'h10;

    logic               ACLK;
    logic               ARESETN;
    logic [AW-1:0]      ARADDR;
    logic [2:0]         ARPROT;
    logic               ARVALID;
    logic               ARREADY;
    logic [31:0]        RDATA;
    logic [1:0]         RRESP;
    logic               RVALID;
    logic               RREADY;
    logic [AW-1:0]      AWADDR;
    logic [2:0]         AWPROT;
    logic               AWVALID;
    logic               AWREADY;
    logic [31:0]        WDATA;
    logic [3:0]         WSTRB;
    logic               WVALID;
    logic               WREADY;
    logic [1:0]         BRESP;
    logic               BVALID;
    logic               BREADY;
    logic [NR*32-1:0]   reg_out;
    logic [NR*32-1:0]   ro_in;
`ifdef AXIL_REGBANK_WPULSE_EN
    logic [NR-1:0]      wr_pulse;
`endif

    axil_regbank #(
        .NUM_REGS  (NR),
        .ADDR_W    (AW),
        .RESET_VAL (32'h0000_0000),
        .RO_MASK   (ROM)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .reg_out (reg_out),
        .ro_in   (ro_in)
`ifdef AXIL_REGBANK_WPULSE_EN
        ,
        .wr_pulse (wr_pulse)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl    [NR];
    logic [31:0] ro_val [NR];

    always_comb begin
        ro_in = '0;
        for (int i = 0; i < NR; i++) ro_in[32*i +: 32] = ro_val[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ro(input int idx);
        return (idx < NR) && ROM[idx];
    endfunction

    function automatic logic [31:0] exp_rdata(input int idx);
        if (idx >= NR) return 32'h0;
        if (is_ro(idx)) return ro_val[idx];
        return mdl[idx];
    endfunction

    task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp);
        logic [31:0] m;
        if (idx >= NR || is_ro(idx)) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            m = 32'h0;
            for (int b = 0; b < 4; b++) if (strb[b]) m = m | (32'hFF << (8*b));
            mdl[idx] = (mdl[idx] & ~m) | (data & m);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s reg_out[%0d]", tag, i), reg_out[32*i +: 32], is_ro(i) ? 32'h0 : mdl[i]);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int hold);
        int          idx;
        int          n;
        logic [31:0] ed;
        logic [1:0]  er;
        idx = int'(addr) >> 2;
        ed  = exp_rdata(idx);
        er  = (idx >= NR) ? 2'b10 : 2'b00;
        n   = 0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk("arready_before_hs", ARREADY, 1'b1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        chk("rvalid_pending", RVALID, 1'b0);
        chk("arready_pending", ARREADY, 1'b0);
        @(posedge ACLK); #1;
        chk("rvalid", RVALID, 1'b1);
        chk($sformatf("rdata@%02h", addr), RDATA, ed);
        chk($sformatf("rresp@%02h", addr), RRESP, er);
        for (int h = 0; h < hold; h++) begin
            @(posedge ACLK); #1;
            chk("rvalid_hold", RVALID, 1'b1);
            chk("rdata_hold", RDATA, ed);
            chk("arready_hold", ARREADY, 1'b0);
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        chk("rvalid_clear", RVALID, 1'b0);
        chk("rdata_clear", RDATA, 32'h0);
        chk("arready_again", ARREADY, 1'b1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int bhold);
        int         idx;
        int         cyc;
        bit         aw_done;
        bit         w_done;
        bit         aw_hs;
        bit         w_hs;
        logic [1:0] er;
        idx = int'(addr) >> 2;
        model_write(idx, data, strb, er);
        cyc = 0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 30) begin
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge ACLK); #1;
            cyc++;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk("aw_w_accepted", {31'h0, aw_done && w_done}, 32'h1);
        chk("bvalid_not_early", BVALID, 1'b0);
        @(posedge ACLK); #1;
        chk("bvalid_rise", BVALID, 1'b1);
        chk($sformatf("bresp@%02h", addr), BRESP, er);
        chk_regs("commit");
`ifdef AXIL_REGBANK_WPULSE_EN
        chk("wr_pulse_rise", wr_pulse, (er == 2'b00 && strb != 4'h0) ? (32'h1 << idx) : 32'h0);
`endif
        for (int h = 0; h < bhold; h++) begin
            @(posedge ACLK); #1;
            chk("bvalid_hold", BVALID, 1'b1);
            chk("awready_hold", AWREADY, 1'b0);
            chk("wready_hold", WREADY, 1'b0);
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        chk("bvalid_clear", BVALID, 1'b0);
        chk("awready_again", AWREADY, 1'b1);
`ifdef AXIL_REGBANK_WPULSE_EN
        chk("wr_pulse_one_cycle", wr_pulse, 32'h0);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r;
        logic [7:0]  a;
        int          idx;
        ARESETN = 1'b0;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        for (int i = 0; i < NR; i++) ro_val[i] = 32'h0;
        model_reset();

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_arready", ARREADY, 1'b0);
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_rresp", RRESP, 2'b00);
        chk("rst_awready", AWREADY, 1'b0);
        chk("rst_wready", WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_bresp", BRESP, 2'b00);
        chk_regs("rst");
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        chk("rel_arready", ARREADY, 1'b1);
        chk("rel_awready", AWREADY, 1'b1);
        chk("rel_wready", WREADY, 1'b1);

        for (int i = 0; i < NR; i++) do_read(8'(4*i), 3);

        do_write(8'h0C, 32'hDEAD_BEEF, 4'hF, 2, 0, 0);
        do_write(8'h0C, 32'h0000_0000, 4'hF, 0, 0, 0);
        do_write(8'h0C, 32'hDEAD_BEEF, 4'hF, 0, 2, 0);
        do_write(8'h0C, 32'h0000_0000, 4'hF, 0, 0, 0);
        do_write(8'h0C, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(8'h0C, 0);

        do_write(8'h08, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(8'h08, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        chk("merge_reg2", reg_out[64 +: 32], 32'h11BB_33DD);
        do_read(8'h09, 1);

        ro_val[4] = 32'hCAFE_0004;
        do_read(8'h10, 0);
        do_write(8'h10, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_read(8'h10, 0);
        do_read(8'h20, 0);
        do_write(8'h20, 32'h8765_4321, 4'hF, 1, 0, 0);
        do_write(8'h14, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);

        do_write(8'h18, 32'h0BAD_F00D, 4'hF, 0, 0, 5);

        // AW captured, W still outstanding when reset hits
        AWADDR = 8'h08; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        chk("midrst_aw_full", AWREADY, 1'b0);
        chk("midrst_w_open", WREADY, 1'b1);
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        model_reset();
        @(posedge ACLK); #1;
        chk("midrst_awready", AWREADY, 1'b1);
        chk("midrst_wready", WREADY, 1'b1);
        chk_regs("midrst");
        WDATA = 32'h5555_AAAA; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge ACLK); #1;
            chk("midrst_no_bvalid", BVALID, 1'b0);
        end
        chk_regs("midrst_w_only");
        AWADDR = 8'h08; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        chk("midrst_late_aw_b0", BVALID, 1'b0);
        @(posedge ACLK); #1;
        model_write(2, 32'h5555_AAAA, 4'hF, r);
        chk("midrst_late_aw_b1", BVALID, 1'b1);
        chk("midrst_late_aw_resp", BRESP, r);
        chk_regs("midrst_late_aw");
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) ro_val[4] = $urandom;
            ro_val[$urandom_range(0, NR-1)] = $urandom;
            idx = $urandom_range(0, 11);
            a = 8'(4*idx + $urandom_range(0, 3));
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            idx = $urandom_range(0, 11);
            a = 8'(4*idx + $urandom_range(0, 3));
            do_read(a, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_regbank.md
Name: axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 8-register slave.
- Adds NUM_REGS depth, WSTRB byte merge, per-register read-only mask, SLVERR decode, and fully independent AW/W capture.
- Sits on the PS/interconnect AXI4-Lite port and exposes registers to fabric logic.
- One outstanding read and one outstanding write at a time.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (1..64).
- ADDR_W, 8, AXI address bits decoded; requires 2^(ADDR_W-2) >= NUM_REGS.
- RESET_VAL, 32'h0000_0000, reset value of every RW register.
- RO_MASK, {NUM_REGS{1'b0}}, bit i set means register i is read-only and sourced from ro_in.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous, active-low reset.
- ARADDR  in  ADDR_W  read address.
- ARPROT  in  3  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- AWADDR  in  ADDR_W  write address.
- AWPROT  in  3  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- reg_out  out  NUM_REGS*32  flattened register contents; reg i at [32i+31:32i].
- ro_in  in  NUM_REGS*32  read-only register sources, same packing.

Behaviour:
- Reset (ARESETN=0 at a rising edge): all READY/VALID outputs 0, RDATA 0, RRESP/BRESP 00, AW/W buffers empty, RW registers = RESET_VAL.
- Reset mid-transaction discards any pending transfer.
- Decode: idx = addr[ADDR_W-1:2]; addr[1:0] ignored.
  - idx >= NUM_REGS: SLVERR (2'b10).
  - Otherwise OKAY (2'b00).
- Read path:
  - ARREADY = !RVALID && !ar_pending, registered: it goes 1 the first cycle after reset release.
  - On ARVALID&&ARREADY at edge t, RVALID=1 and RDATA/RRESP are valid after edge t+1 (1-cycle latency).
  - RDATA = ro_in slice if RO_MASK[idx], else the register; 0 on SLVERR.
  - RDATA/RRESP/RVALID are held stable until RVALID&&RREADY; then RVALID=0 and RDATA=0.
- Write path: AW and W are captured independently into one-entry buffers.
  - AWREADY = !aw_full && !BVALID.
  - WREADY = !w_full && !BVALID.
  - Either channel may arrive first, or both in the same cycle.
  - At the edge after both buffers are full: commit, set BVALID=1 with BRESP, clear both buffers.
  - Commit rule: for each byte b with WSTRB[b]=1, reg[idx][8b+7:8b] = WDATA byte.
  - Write to an RO_MASK register, or idx out of range: no change, BRESP=SLVERR.
  - WSTRB=0: no change, BRESP=OKAY.
  - BVALID is held until BREADY. AW/W are not accepted while BVALID=1.
- Latency: AW and W handshake on the same edge t, then reg_out updates and BVALID=1 after edge t+1.
- Read/write collision: a read and a commit to the same register on the same edge return the old value; the new value is visible to the next read.
- reg_out is driven directly from the registers (no extra pipeline). RO slots in reg_out read as 0.

Optional Feature:
- Macro: AXIL_REGBANK_WPULSE_EN.
- Defined: adds output wr_pulse [NUM_REGS]. Bit idx is high for exactly one cycle, coincident with the commit edge (same cycle BVALID rises), only for OKAY writes with WSTRB != 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - AXIL_DATA_W = 32, AXIL_STRB_W = 4.
  - Function for byte-lane merge.
- Sub-module axil_wr_capture: AW/W one-entry buffers, READY generation, and the "both full" commit strobe. The top level holds decode, register array, and read path.

Test Plan:
- Reset release, then read idx 0..7 (NUM_REGS=8) -> RDATA=0x0000_0000, RRESP=00, 1-cycle latency, ARREADY low while RVALID is held with RREADY=0 for 3 cycles.
- W before AW by 2 cycles: WDATA=0xDEAD_BEEF, WSTRB=4'hF, AWADDR=0x0C -> reg 3 = 0xDEAD_BEEF, BRESP=00; repeat with AW first and with AW/W in the same cycle -> identical result and latency.
- Reg 2 = 0x1122_3344, then write 0xAABB_CCDD with WSTRB=4'b0101 -> reg 2 = 0x11BB_33DD.
- RO_MASK=8'h10, ro_in[4]=0xCAFE_0004: read 0x10 -> 0xCAFE_0004/OKAY; write 0x10 -> BRESP=10, value unchanged; read/write 0x20 (idx 8) -> SLVERR, RDATA 0.
- Hold BREADY=0 for 5 cycles -> BVALID stays 1 and AWREADY/WREADY stay 0.
- ARESETN low mid-write (AW captured, W pending) -> buffers clear, no register change, no BVALID after release.
- With AXIL_REGBANK_WPULSE_EN: a write to reg 5 -> wr_pulse[5] is high for one cycle, aligned with the BVALID rise; a SLVERR write produces no pulse.
